// File: rtl/pulse_req_arbiter_if.sv
// Request/grant/resource handshake bundle for pulse_req_arbiter.
// master: arbiter side; slave: requesters plus shared resource side.
interface pulse_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_in;
  logic               res_done;
  logic               res_start;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               busy;
  logic [NUM_REQ-1:0] pending;
  logic               timeout_err;

  modport master (
    input  req_in, res_done,
    output res_start, grant, grant_idx, busy, pending, timeout_err
  );

  modport slave (
    output req_in, res_done,
    input  res_start, grant, grant_idx, busy, pending, timeout_err
  );
endinterface

// File: rtl/pulse_req_arbiter.sv
// Round-robin arbiter: edge-captured sticky requests share one single-transaction resource.
// Optional WAIT watchdog enabled by defining ARB_TIMEOUT_EN.
module pulse_req_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned IDX_W       = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input logic                 CLK,
  input logic                 RST,
  pulse_req_arbiter_if.master bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (32'd1 << CNT_W)) begin : g_bad_cfg
    $error("pulse_req_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] req_q, req_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic               res_start_q, res_start_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] rise;
  logic [NUM_REQ-1:0] clr;
  logic [NUM_REQ-1:0] sel_oh;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_vld;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  // Round-robin pick: first pending bit after last_idx, wrapping.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!sel_vld && pending_q[IDX_W'((32'(last_idx_q) + 32'd1 + i) % NUM_REQ)]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'((32'(last_idx_q) + 32'd1 + i) % NUM_REQ);
      end
    end
    sel_oh = sel_vld ? (NUM_REQ'(1) << sel_idx) : '0;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
    res_start_d = 1'b0;
    clr         = '0;
    req_d       = bus.req_in;
    rise        = bus.req_in & ~req_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d     = START;
          grant_d     = sel_oh;
          grant_idx_d = sel_idx;
          clr         = sel_oh;
          res_start_d = 1'b1;
        end
      end
      START: begin
        state_d = WAIT;
`ifdef ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      WAIT: begin
        // Completion beats a timeout landing in the same cycle.
        if (bus.res_done) begin
          state_d    = IDLE;
          grant_d    = '0;
          last_idx_d = grant_idx_q;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d       = IDLE;
          grant_d       = '0;
          last_idx_d    = grant_idx_q;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // A fresh rise on the bit being granted survives the clear.
    pending_d = (pending_q & ~clr) | rise;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      req_q       <= '0;
      pending_q   <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      last_idx_q  <= IDX_W'(NUM_REQ - 1);
      res_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      pending_q   <= pending_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
      res_start_q <= res_start_d;
      busy_q      <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.res_start = res_start_q;
  assign bus.grant     = grant_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_pulse_req_arbiter.sv
// Self-checking bench for pulse_req_arbiter: scoreboard of expected grants plus a
// resource responder that answers res_start with res_done after a set latency.
module tb_pulse_req_arbiter;
  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned TIMEOUT_CYC = 10;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pulse_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  pulse_req_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .IDX_W      (IDX_W),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    int                 idx;
    logic [NUM_REQ-1:0] pend;
  } exp_t;

  exp_t        sb[$];
  int          n_vec     = 0;
  int          n_err     = 0;
  int          start_cnt = 0;
  bit          auto_en   = 1'b0;
  int unsigned auto_lat  = 1;
  bit          kick      = 1'b0;
  int unsigned resp_left = 0;

  // Resource model: done pulse auto_lat cycles after res_start, or on kick.
  always @(negedge CLK) begin
    if (RST) begin
      resp_left    = 0;
      bus.res_done = 1'b0;
    end else begin
      bus.res_done = 1'b0;
      if (resp_left != 0) begin
        resp_left--;
        if (resp_left == 0) bus.res_done = 1'b1;
      end
      if (kick) begin
        bus.res_done = 1'b1;
        kick         = 1'b0;
      end
      if (bus.res_start === 1'b1) begin
        start_cnt++;
        if (auto_en) resp_left = auto_lat;
      end
    end
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic wait_start(input int budget, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < budget) begin
      step();
      cyc++;
      if (bus.res_start === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic do_reset();
    RST         = 1'b1;
    bus.req_in  = '0;
    auto_en     = 1'b0;
    kick        = 1'b0;
    sb.delete();
    repeat (2) step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST        = 1'b1;
    bus.req_in = 4'b1111;
    repeat (3) step();
    n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    n_vec++; if (bus.grant_idx !== 2'd0) begin n_err++; $display("FAIL reset_grant_idx: got %0d want 0", bus.grant_idx); end
    n_vec++; if (bus.res_start !== 1'b0) begin n_err++; $display("FAIL reset_res_start: got %b want 0", bus.res_start); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.pending !== 4'b0000) begin n_err++; $display("FAIL reset_pending: got %b want 0000", bus.pending); end
    n_vec++; if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err: got %b want 0", bus.timeout_err); end
    RST = 1'b0;
    step();
    n_vec++; if (bus.pending !== 4'b1111 || bus.grant !== 4'b0000) begin n_err++; $display("FAIL reset_release_edge: pending %b grant %b want 1111 0000", bus.pending, bus.grant); end
  endtask

  task automatic test_single();
    int cyc; bit seen; exp_t e;
    do_reset();
    auto_en  = 1'b1;
    auto_lat = 2;
    bus.req_in = 4'b0100;
    sb.push_back('{2, 4'b0000});
    step();
    n_vec++; if (bus.pending !== 4'b0100 || bus.grant !== 4'b0000) begin n_err++; $display("FAIL single_capture: pending %b grant %b want 0100 0000", bus.pending, bus.grant); end
    wait_start(10, cyc, seen);
    n_vec++; if (!seen || cyc != 1) begin n_err++; $display("FAIL single_latency: seen %0b cycles %0d want 1 1", seen, cyc); end
    e = sb.pop_front();
    n_vec++; if (bus.grant_idx !== IDX_W'(e.idx) || bus.grant !== (4'b0001 << e.idx)) begin n_err++; $display("FAIL single_grant: idx %0d grant %b want %0d", bus.grant_idx, bus.grant, e.idx); end
    n_vec++; if (bus.pending !== e.pend || bus.busy !== 1'b1) begin n_err++; $display("FAIL single_busy: pending %b busy %b want %b 1", bus.pending, bus.busy, e.pend); end
    bus.req_in = '0;
    step();
    n_vec++; if (bus.res_start !== 1'b0 || bus.grant !== 4'b0100) begin n_err++; $display("FAIL single_one_pulse: res_start %b grant %b want 0 0100", bus.res_start, bus.grant); end
    step();
    n_vec++; if (bus.grant !== 4'b0100 || bus.busy !== 1'b1) begin n_err++; $display("FAIL single_hold: grant %b busy %b want 0100 1", bus.grant, bus.busy); end
    step();
    n_vec++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.grant_idx !== 2'd2) begin n_err++; $display("FAIL single_done: grant %b busy %b idx %0d want 0000 0 2", bus.grant, bus.busy, bus.grant_idx); end
  endtask

  task automatic test_multi();
    int cyc; bit seen; exp_t e; int s0;
    do_reset();
    auto_en  = 1'b1;
    auto_lat = 1;
    s0 = start_cnt;
    bus.req_in = 4'b1011;
    sb.push_back('{0, 4'b1010});
    sb.push_back('{1, 4'b1000});
    sb.push_back('{3, 4'b0000});
    step();
    bus.req_in = '0;
    n_vec++; if (bus.pending !== 4'b1011) begin n_err++; $display("FAIL multi_capture: pending %b want 1011", bus.pending); end
    for (int k = 0; k < 3; k++) begin
      wait_start(12, cyc, seen);
      e = sb.pop_front();
      n_vec++; if (!seen || cyc != ((k == 0) ? 1 : 3)) begin n_err++; $display("FAIL multi_spacing: grant %0d seen %0b cycles %0d want %0d", k, seen, cyc, (k == 0) ? 1 : 3); end
      n_vec++; if (bus.grant_idx !== IDX_W'(e.idx) || bus.grant !== (4'b0001 << e.idx)) begin n_err++; $display("FAIL multi_grant: idx %0d grant %b want %0d", bus.grant_idx, bus.grant, e.idx); end
      n_vec++; if (bus.pending !== e.pend) begin n_err++; $display("FAIL multi_pending: pending %b want %b", bus.pending, e.pend); end
    end
    repeat (6) step();
    n_vec++; if (start_cnt - s0 != 3 || bus.busy !== 1'b0) begin n_err++; $display("FAIL multi_starts: starts %0d busy %b want 3 0", start_cnt - s0, bus.busy); end
  endtask

  task automatic test_held();
    int cyc; bit seen; exp_t e; int s0;
    do_reset();
    auto_en  = 1'b1;
    auto_lat = 2;
    s0 = start_cnt;
    bus.req_in = 4'b0010;
    sb.push_back('{1, 4'b0000});
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.res_start === 1'b1 && sb.size() != 0) begin
        e = sb.pop_front();
        n_vec++; if (bus.grant_idx !== IDX_W'(e.idx) || bus.pending !== e.pend) begin n_err++; $display("FAIL held_grant: idx %0d pending %b want %0d %b", bus.grant_idx, bus.pending, e.idx, e.pend); end
      end
    end
    bus.req_in = '0;
    repeat (4) step();
    n_vec++; if (start_cnt - s0 != 1) begin n_err++; $display("FAIL held_starts: starts %0d want 1", start_cnt - s0); end
    auto_lat = 4;
    bus.req_in = 4'b0010;
    sb.push_back('{1, 4'b0000});
    wait_start(10, cyc, seen);
    e = sb.pop_front();
    n_vec++; if (!seen || bus.grant_idx !== IDX_W'(e.idx)) begin n_err++; $display("FAIL held_first: seen %0b idx %0d want %0d", seen, bus.grant_idx, e.idx); end
    bus.req_in = '0;
    step();
    bus.req_in = 4'b0010;
    step();
    n_vec++; if (bus.pending !== 4'b0010 || bus.grant !== 4'b0010) begin n_err++; $display("FAIL held_repend: pending %b grant %b want 0010 0010", bus.pending, bus.grant); end
    sb.push_back('{1, 4'b0000});
    wait_start(12, cyc, seen);
    e = sb.pop_front();
    n_vec++; if (!seen || bus.grant_idx !== IDX_W'(e.idx) || bus.pending !== e.pend) begin n_err++; $display("FAIL held_second: seen %0b idx %0d pending %b want %0d %b", seen, bus.grant_idx, bus.pending, e.idx, e.pend); end
    bus.req_in = '0;
    repeat (8) step();
  endtask

  task automatic test_set_wins();
    int cyc; bit seen; exp_t e; int c;
    do_reset();
    auto_en  = 1'b1;
    auto_lat = 6;
    bus.req_in = 4'b0100;
    sb.push_back('{2, 4'b0000});
    wait_start(10, cyc, seen);
    e = sb.pop_front();
    n_vec++; if (!seen || bus.grant_idx !== IDX_W'(e.idx)) begin n_err++; $display("FAIL sw_first: seen %0b idx %0d want %0d", seen, bus.grant_idx, e.idx); end
    bus.req_in = 4'b0001;
    step();
    bus.req_in = '0;
    c = 0;
    while (bus.busy !== 1'b0 && c < 20) begin step(); c++; end
    n_vec++; if (bus.busy !== 1'b0 || bus.pending !== 4'b0001) begin n_err++; $display("FAIL sw_idle: busy %b pending %b want 0 0001", bus.busy, bus.pending); end
    bus.req_in = 4'b0001;
    sb.push_back('{0, 4'b0001});
    sb.push_back('{0, 4'b0000});
    wait_start(3, cyc, seen);
    bus.req_in = '0;
    e = sb.pop_front();
    n_vec++; if (!seen || cyc != 1 || bus.grant_idx !== IDX_W'(e.idx) || bus.pending !== e.pend) begin n_err++; $display("FAIL sw_set_wins: seen %0b cyc %0d idx %0d pending %b want 1 1 %0d %b", seen, cyc, bus.grant_idx, bus.pending, e.idx, e.pend); end
    wait_start(15, cyc, seen);
    e = sb.pop_front();
    n_vec++; if (!seen || bus.grant_idx !== IDX_W'(e.idx) || bus.pending !== e.pend) begin n_err++; $display("FAIL sw_regrant: seen %0b idx %0d pending %b want %0d %b", seen, bus.grant_idx, bus.pending, e.idx, e.pend); end
    repeat (10) step();
  endtask

  task automatic test_rst_mid();
    int cyc; bit seen; exp_t e; int s0;
    do_reset();
    auto_en  = 1'b1;
    auto_lat = 30;
    bus.req_in = 4'b0111;
    sb.push_back('{0, 4'b0110});
    step();
    bus.req_in = '0;
    wait_start(10, cyc, seen);
    e = sb.pop_front();
    n_vec++; if (!seen || bus.grant_idx !== IDX_W'(e.idx) || bus.pending !== e.pend) begin n_err++; $display("FAIL rst_first: seen %0b idx %0d pending %b want %0d %b", seen, bus.grant_idx, bus.pending, e.idx, e.pend); end
    step();
    n_vec++; if (bus.busy !== 1'b1 || bus.grant !== 4'b0001) begin n_err++; $display("FAIL rst_pre: busy %b grant %b want 1 0001", bus.busy, bus.grant); end
    #2 RST = 1'b1;
    #1;
    n_vec++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL rst_grant: got %b want 0000", bus.grant); end
    n_vec++; if (bus.busy !== 1'b0 || bus.res_start !== 1'b0) begin n_err++; $display("FAIL rst_busy: busy %b res_start %b want 0 0", bus.busy, bus.res_start); end
    n_vec++; if (bus.pending !== 4'b0000 || bus.grant_idx !== 2'd0 || bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_state: pending %b idx %0d terr %b want 0000 0 0", bus.pending, bus.grant_idx, bus.timeout_err); end
    step();
    RST = 1'b0;
    s0 = start_cnt;
    repeat (20) step();
    n_vec++; if (start_cnt != s0 || bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin n_err++; $display("FAIL rst_no_grant: starts %0d busy %b grant %b want 0 0 0000", start_cnt - s0, bus.busy, bus.grant); end
  endtask

  task automatic test_timeout();
    int cyc; bit seen; exp_t e; int c;
    do_reset();
    auto_en = 1'b0;
`ifdef ARB_TIMEOUT_EN
    bus.req_in = 4'b0011;
    sb.push_back('{0, 4'b0010});
    sb.push_back('{1, 4'b0000});
    step();
    bus.req_in = '0;
    wait_start(5, cyc, seen);
    e = sb.pop_front();
    n_vec++; if (!seen || bus.grant_idx !== IDX_W'(e.idx)) begin n_err++; $display("FAIL to_first: seen %0b idx %0d want %0d", seen, bus.grant_idx, e.idx); end
    c = 0;
    while (bus.timeout_err !== 1'b1 && c < 40) begin step(); c++; end
    n_vec++; if (c != 11) begin n_err++; $display("FAIL to_delay: cycles after start %0d want 11", c); end
    n_vec++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin n_err++; $display("FAIL to_drop: grant %b busy %b want 0000 0", bus.grant, bus.busy); end
    step();
    e = sb.pop_front();
    n_vec++; if (bus.timeout_err !== 1'b0 || bus.res_start !== 1'b1) begin n_err++; $display("FAIL to_pulse: terr %b res_start %b want 0 1", bus.timeout_err, bus.res_start); end
    n_vec++; if (bus.grant_idx !== IDX_W'(e.idx) || bus.pending !== e.pend) begin n_err++; $display("FAIL to_next: idx %0d pending %b want %0d %b", bus.grant_idx, bus.pending, e.idx, e.pend); end
    c = 0;
    while (bus.busy !== 1'b0 && c < 40) begin step(); c++; end
    n_vec++; if (bus.busy !== 1'b0 || c != 11) begin n_err++; $display("FAIL to_second: busy %b cycles %0d want 0 11", bus.busy, c); end
`else
    bus.req_in = 4'b0001;
    sb.push_back('{0, 4'b0000});
    step();
    bus.req_in = '0;
    wait_start(5, cyc, seen);
    e = sb.pop_front();
    n_vec++; if (!seen || bus.grant_idx !== IDX_W'(e.idx)) begin n_err++; $display("FAIL hold_first: seen %0b idx %0d want %0d", seen, bus.grant_idx, e.idx); end
    c = 0;
    for (int k = 0; k < 120; k++) begin
      step();
      if (bus.grant === 4'b0001 && bus.busy === 1'b1 && bus.timeout_err === 1'b0) c++;
    end
    n_vec++; if (c != 120) begin n_err++; $display("FAIL hold_forever: held cycles %0d want 120", c); end
    kick = 1'b1;
    c = 0;
    while (bus.busy !== 1'b0 && c < 10) begin step(); c++; end
    n_vec++; if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin n_err++; $display("FAIL hold_release: busy %b grant %b want 0 0000", bus.busy, bus.grant); end
`endif
  endtask

  initial begin
    bus.req_in = '0;
    test_reset();
    test_single();
    test_multi();
    test_held();
    test_set_wins();
    test_rst_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
